// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types and sizes for the RC4 stages (init, key-schedule swap, decrypt).
package ksa_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;

    // Key-schedule swap pass states
    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_WAIT_I,
        S_GET_I,
        S_RD_J,
        S_WAIT_J,
        S_GET_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } ksa_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// ksa_key_sel: key index k (0..KEY_BYTES-1, wrapping) and the matching key byte.
// Byte 0 is the most significant byte of i_key.
module ksa_key_sel
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_advance,
    input  logic [8*KEY_BYTES-1:0] i_key,
    output logic [DATA_W-1:0]      o_key_byte
);

    logic [7:0] r_k;

    // Key index counter: cleared at pass start, wraps at KEY_BYTES without a divider
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_k <= '0;
        end else if (i_advance) begin
            r_k <= (r_k == 8'(KEY_BYTES - 1)) ? '0 : r_k + 8'd1;
        end
    end

    // Byte mux selecting key[k]
    always_comb begin
        o_key_byte = '0;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (r_k == 8'(b)) begin
                o_key_byte = i_key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_swap.sv
// ksa_swap: RC4 key-scheduling swap pass over the shared s_memory port.
// For i = 0..255: j += S[i] + key[i mod KEY_BYTES]; swap S[i], S[j].
// Optional macro KSA_SWAP_SKIP_SELF_EN: when i == j the two writes are skipped.
module ksa_swap
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES  = 3,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_data,
    output logic                   mem_wren,
    input  logic [DATA_W-1:0]      mem_q,
    output logic                   busy,
    output logic                   done
);

    ksa_state_t             r_state;
    logic [ADDR_W-1:0]      r_i;
    logic [ADDR_W-1:0]      r_j;
    logic [DATA_W-1:0]      r_si;
    logic [DATA_W-1:0]      r_sj;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_wait;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;
    logic                   r_wren;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_iter_end;
    logic [DATA_W-1:0]      w_key_byte;

    assign mem_address = r_addr;
    assign mem_data    = r_data;
    assign mem_wren    = r_wren;
    assign busy        = r_busy;
    assign done        = r_done;

    // Iteration-boundary and start-acceptance decode
    always_comb begin
        w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
        w_iter_end = (r_state == S_WR_J) && (r_i != 8'hFF);
`ifdef KSA_SWAP_SKIP_SELF_EN
        if (r_state == S_GET_J && r_i == r_j && r_i != 8'hFF) begin
            w_iter_end = 1'b1;
        end
`endif
    end

    ksa_key_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .i_clk      (CLOCK_50),
        .i_reset    (reset),
        .i_clear    (w_accept),
        .i_advance  (w_iter_end),
        .i_key      (r_key),
        .o_key_byte (w_key_byte)
    );

    // Swap-pass FSM with registered memory-port and status outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_key   <= '0;
            r_wait  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_RD_I: begin
                    r_addr  <= r_i;
                    r_wren  <= 1'b0;
                    r_wait  <= 8'(MEM_RD_LAT - 1);
                    r_state <= S_WAIT_I;
                end
                S_WAIT_I: begin
                    if (r_wait == '0) r_state <= S_GET_I;
                    else              r_wait  <= r_wait - 8'd1;
                end
                S_GET_I: begin
                    r_si    <= mem_q;
                    r_j     <= r_j + mem_q + w_key_byte;
                    r_state <= S_RD_J;
                end
                S_RD_J: begin
                    r_addr  <= r_j;
                    r_wait  <= 8'(MEM_RD_LAT - 1);
                    r_state <= S_WAIT_J;
                end
                S_WAIT_J: begin
                    if (r_wait == '0) r_state <= S_GET_J;
                    else              r_wait  <= r_wait - 8'd1;
                end
                S_GET_J: begin
                    r_sj <= mem_q;
`ifdef KSA_SWAP_SKIP_SELF_EN
                    if (r_i == r_j) begin
                        if (r_i == 8'hFF) begin
                            r_state <= S_DONE;
                        end else begin
                            r_i     <= r_i + 8'd1;
                            r_state <= S_RD_I;
                        end
                    end else begin
                        r_state <= S_WR_I;
                    end
`else
                    r_state <= S_WR_I;
`endif
                end
                S_WR_I: begin
                    r_addr  <= r_i;
                    r_data  <= r_sj;
                    r_wren  <= 1'b1;
                    r_state <= S_WR_J;
                end
                S_WR_J: begin
                    r_addr <= r_j;
                    r_data <= r_si;
                    r_wren <= 1'b1;
                    if (r_i == 8'hFF) begin
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= r_i + 8'd1;
                        r_state <= S_RD_I;
                    end
                end
                S_DONE: begin
                    r_wren <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            // Start acceptance is shared by IDLE and DONE; placed last so it overrides the DONE defaults
            if (w_accept) begin
                r_key   <= secret_key;
                r_i     <= '0;
                r_j     <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_state <= S_RD_I;
            end
        end
    end

endmodule

// File: tb/tb_ksa_swap.sv
// tb_ksa_swap: behavioural s_memory (1-cycle read latency) plus a golden RC4 KSA model.
// Expected writes are queued per pass and compared as the DUT issues them.
module tb_ksa_swap;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [23:0] key;
        int          iter;
        logic [7:0]  a0;
        logic [7:0]  d0;
        logic [7:0]  a1;
        logic [7:0]  d1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;
    logic        busy;
    logic        done;

    logic [7:0]  mem [256];
    logic        preload = 1'b0;
    logic [7:0]  gs [256];
    int          iter_wpos [256];
    int          idx100;
    int          exp_cycles;

    wr_t         sb [$];
    wr_t         wlog [512];
    int          wcount = 0;
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;

    ksa_swap #(
        .KEY_BYTES  (3),
        .MEM_RD_LAT (1)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .start       (start),
        .secret_key  (secret_key),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural s_memory: synchronous write, registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (mem_wren === 1'b1) begin
            mem[mem_address] <= mem_data;
        end
        mem_q <= mem[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: pop the scoreboard on every DUT write
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            wr_t got;
            wr_t e;
            got = '{mem_address, mem_data};
            if (wcount < 512) wlog[wcount] = got;
            wcount++;
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL write_extra: got addr %0h data %0h expected no write", got.a, got.d);
            end else begin
                e = sb.pop_front();
                check("write", {16'h0, got}, {16'h0, e});
            end
        end
    end

    task automatic do_preload();
        @(posedge clk);
        #1 preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        for (int a = 0; a < 256; a++) gs[a] = 8'(a);
    endtask

    // Golden KSA over gs[], pushing the writes the DUT must issue
    task automatic golden_pass(input logic [23:0] key);
        logic [7:0] j = 8'd0;
        logic [7:0] t;
        logic [7:0] kb;
        int np = 0;
        int nself = 0;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(key >> (8 * (2 - (i % 3))));
            j  = j + gs[i] + kb;
            if (i == 100) idx100 = np;
            iter_wpos[i] = np;
`ifdef KSA_SWAP_SKIP_SELF_EN
            if (i == int'(j)) begin
                nself++;
                iter_wpos[i] = -1;
            end else begin
                sb.push_back('{8'(i), gs[j]});
                sb.push_back('{j, gs[i]});
                np += 2;
            end
`else
            sb.push_back('{8'(i), gs[j]});
            sb.push_back('{j, gs[i]});
            np += 2;
`endif
            t     = gs[i];
            gs[i] = gs[j];
            gs[j] = t;
        end
        exp_cycles = 1 + 256 * 8 - 2 * nself;
    endtask

    task automatic run_pass(input logic [23:0] key, input bit pulse_busy, input bit reload);
        int t0;
        int n = 0;
        int bad = 0;
        if (reload) do_preload();
        sb.delete();
        wcount = 0;
        golden_pass(key);
        secret_key = key;
        @(posedge clk);
        #1 start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_after_start", {31'd0, done}, 32'd0);
        while (done !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            start = pulse_busy && (n == 5 || n == 700 || n == 1500);
            if (pulse_busy && n == 700) secret_key = ~key;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            ntests++;
            nfail++;
            $display("FAIL done_timeout: done still %b after %0d cycles, expected 1", done, n);
        end else begin
            check("done_latency", 32'(cyc - t0), 32'(exp_cycles));
        end
        for (int a = 0; a < 256; a++) if (mem[a] !== gs[a]) bad++;
        check("mem_vs_golden", 32'(bad), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    vec_t tv [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        int wsave;

        tv[0] = '{24'h000000, 2, 8'h02, 8'h03, 8'h03, 8'h02};
        tv[1] = '{24'h010203, 0, 8'h00, 8'h01, 8'h01, 8'h00};
        tv[2] = '{24'h010203, 1, 8'h01, 8'h03, 8'h03, 8'h00};
        tv[3] = '{24'h000000, 0, 8'h00, 8'h00, 8'h00, 8'h00};

        reset      = 1'b1;
        start      = 1'b0;
        secret_key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {24'd0, mem_address}, 32'd0);
        check("rst_data", {24'd0, mem_data}, 32'd0);
        reset = 1'b0;

        // Table-driven: specific iteration writes for known keys
        for (int r = 0; r < 4; r++) begin
            run_pass(tv[r].key, 1'b0, 1'b1);
            p = iter_wpos[tv[r].iter];
            if (p >= 0) begin
                check("vec_a0", {24'd0, wlog[p].a},     {24'd0, tv[r].a0});
                check("vec_d0", {24'd0, wlog[p].d},     {24'd0, tv[r].d0});
                check("vec_a1", {24'd0, wlog[p + 1].a}, {24'd0, tv[r].a1});
                check("vec_d1", {24'd0, wlog[p + 1].d}, {24'd0, tv[r].d1});
            end
        end

        // Reset mid-pass on the first write of iteration 100
        do_preload();
        sb.delete();
        wcount = 0;
        golden_pass(24'h5A3C96);
        secret_key = 24'h5A3C96;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(mem_wren === 1'b1 && wcount == idx100) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            ntests++;
            nfail++;
            $display("FAIL abort_wait: write %0d not seen, got %0d writes", idx100, wcount);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wren", {31'd0, mem_wren}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        wsave = wcount;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_writes", 32'(wcount), 32'(wsave));
        sb.delete();
        run_pass(24'h5A3C96, 1'b0, 1'b1);

        // Start pulses and key change while busy, then restart from DONE without reload
        run_pass(24'h13579B, 1'b1, 1'b1);
        run_pass(24'hC0FFEE, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
